proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Control unit FSM for the 16-bit processor; the issuing end of the register/ALU datapath control interface.
- Owns the program counter (PC) and instruction register (IR).
- Fetches instructions from the asynchronous instruction ROM, decodes them, and sequences register-file, ALU and data-memory control signals one state at a time.
- All datapath control outputs are Moore outputs, decoded only from the current state and IR.

Parameters:
- PC_W, 7, program counter / instruction ROM address width (128 words).
- D_AW, 8, data memory address width.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr_data  in  16  instruction ROM read data for PC_addr; combinational; must be valid during Fetch.
- PC_addr  out  PC_W  current PC, drives the instruction ROM address.
- IR_out  out  16  current instruction register.
- D_addr  out  D_AW  data memory address.
- D_wr  out  1  data memory write enable.
- RF_s  out  1  register-file write mux select: 1 = data memory, 0 = ALU.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file read port A address.
- RF_Rb_addr  out  4  register-file read port B address.
- ALU_s0  out  3  ALU op: 000 pass A, 001 add, 010 sub.
- State  out  4  current state encoding, for debug.
- Halted  out  1  high while in HALT.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - State = INIT, PC = 0, IR = 0.
  - All enables low; all addresses 0; ALU_s0 = 000.
- IR field decode:
  - Opcode IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT.
  - Any other opcode executes as NOOP.
- State encodings: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
- Per-state actions and transitions:
  - INIT: PC cleared; next state FETCH.
  - FETCH: IR <= Instr_data; PC <= PC+1; next state DECODE.
  - DECODE: no enables asserted; next state chosen by opcode.
  - NOOP: next state FETCH.
  - LOAD_A:
    - D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 0.
    - This cycle covers the synchronous data-memory read latency.
    - Next state LOAD_B.
  - LOAD_B: same as LOAD_A but RF_W_en = 1; next state FETCH.
  - STORE: RF_Ra_addr = IR[11:8], D_addr = IR[7:0], D_wr = 1; next state FETCH.
  - ADD:
    - RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0].
    - RF_s = 0, RF_W_en = 1, ALU_s0 = 001.
    - Next state FETCH.
  - SUB: as ADD but ALU_s0 = 010.
  - HALT: Halted = 1; no enables; stays in HALT until Reset.
- Defaults: in any state, signals not listed above hold 0 (ALU_s0 = 000). Enables are asserted only in their listed states.
- Cycle counts, FETCH to next FETCH: NOOP 3, ADD 3, SUB 3, STORE 3, LOAD 4.
- PC:
  - Increments only in FETCH and wraps from 2^PC_W-1 to 0.
  - Holds in all other states, including HALT.
- IR loads only in FETCH and holds otherwise.
- D_wr and RF_W_en are never high in the same cycle.

Test Plan:
- Reset then release with ROM[0] = 0x0000 (NOOP):
  - State sequence INIT, FETCH, DECODE, NOOP, FETCH.
  - PC = 1 at the second FETCH.
  - No enable ever high.
- ADD, ROM[0] = 0x3125:
  - In the ADD cycle: RF_Ra_addr = 1, RF_Rb_addr = 2, RF_W_addr = 5, RF_W_en = 1, ALU_s0 = 001, RF_s = 0.
  - Next state FETCH.
- SUB 0x4347 then LOAD 0x21A3:
  - SUB cycle: ALU_s0 = 010.
  - LOAD_A: D_addr = 0x1A, RF_s = 1, RF_W_en = 0.
  - LOAD_B: RF_W_addr = 3, RF_W_en = 1.
  - Total LOAD latency 4 cycles.
- STORE 0x1B42:
  - STORE cycle: RF_Ra_addr = 0xB, D_addr = 0x42, D_wr = 1, RF_W_en = 0.
- HALT 0x5000 at PC 3:
  - Halted = 1, PC stays 4 for 10+ cycles, all enables 0.
  - Reset returns the block to INIT with PC = 0.
- Reset asserted mid-operation:
  - Assert Reset in LOAD_B between clock edges: outputs clear immediately without waiting for an edge.
  - Undefined opcode 0xF000 decodes to NOOP.
  - PC wrap: after FETCH at PC = 127, PC reads 0.

Source files
------------

// File: rtl/proc_control_unit.sv
// proc_control_unit: multi-cycle control FSM for the 16-bit processor.
// Owns PC and IR, fetches from an asynchronous instruction ROM, decodes the
// opcode and drives register-file, ALU and data-memory control one state at a
// time. All datapath controls are Moore outputs decoded from state and IR.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   Instr_data        ROM word at PC_addr, sampled in FETCH
//   PC_addr, IR_out   program counter and instruction register
//   D_addr, D_wr      data memory address / write enable
//   RF_s              register-file write mux: 1 = data memory, 0 = ALU
//   RF_W_addr/_en     register-file write port
//   RF_Ra/Rb_addr     register-file read ports
//   ALU_s0            ALU op: 000 pass A, 001 add, 010 sub
//   State, Halted     debug state encoding, high while halted
module proc_control_unit #(
    parameter int unsigned PC_W = 7,
    parameter int unsigned D_AW = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       Instr_data,
    output logic [PC_W-1:0]   PC_addr,
    output logic [15:0]       IR_out,
    output logic [D_AW-1:0]   D_addr,
    output logic              D_wr,
    output logic              RF_s,
    output logic [3:0]        RF_W_addr,
    output logic              RF_W_en,
    output logic [3:0]        RF_Ra_addr,
    output logic [3:0]        RF_Rb_addr,
    output logic [2:0]        ALU_s0,
    output logic [3:0]        State,
    output logic              Halted
);

    localparam logic [3:0] StInit   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StNoop   = 4'd3;
    localparam logic [3:0] StLoadA  = 4'd4;
    localparam logic [3:0] StLoadB  = 4'd5;
    localparam logic [3:0] StStore  = 4'd6;
    localparam logic [3:0] StAdd    = 4'd7;
    localparam logic [3:0] StSub    = 4'd8;
    localparam logic [3:0] StHalt   = 4'd9;

    localparam logic [3:0] OpNoop  = 4'h0;
    localparam logic [3:0] OpStore = 4'h1;
    localparam logic [3:0] OpLoad  = 4'h2;
    localparam logic [3:0] OpAdd   = 4'h3;
    localparam logic [3:0] OpSub   = 4'h4;
    localparam logic [3:0] OpHalt  = 4'h5;

    logic [3:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (ir_q[15:12])
                    OpNoop:  state_d = StNoop;
                    OpStore: state_d = StStore;
                    OpLoad:  state_d = StLoadA;
                    OpAdd:   state_d = StAdd;
                    OpSub:   state_d = StSub;
                    OpHalt:  state_d = StHalt;
                    default: state_d = StNoop;  // undefined opcodes behave as NOOP
                endcase
            end
            StNoop:   state_d = StFetch;
            StLoadA:  state_d = StLoadB;
            StLoadB:  state_d = StFetch;
            StStore:  state_d = StFetch;
            StAdd:    state_d = StFetch;
            StSub:    state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StInit) begin
                pc_q <= '0;
            end else if (state_q == StFetch) begin
                ir_q <= Instr_data;
                pc_q <= pc_q + 1'b1;  // wraps naturally at 2^PC_W
            end
        end
    end

    // Moore outputs; reset clears them at once because state and IR reset asynchronously
    always_comb begin
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s0     = 3'b000;
        Halted     = 1'b0;
        case (state_q)
            StLoadA, StLoadB: begin
                D_addr    = D_AW'(ir_q[11:4]);
                RF_s      = 1'b1;
                RF_W_addr = ir_q[3:0];
                // LOAD_A only waits out the synchronous memory read
                RF_W_en   = (state_q == StLoadB);
            end
            StStore: begin
                RF_Ra_addr = ir_q[11:8];
                D_addr     = D_AW'(ir_q[7:0]);
                D_wr       = 1'b1;
            end
            StAdd, StSub: begin
                RF_Ra_addr = ir_q[11:8];
                RF_Rb_addr = ir_q[7:4];
                RF_W_addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == StAdd) ? 3'b001 : 3'b010;
            end
            StHalt: Halted = 1'b1;
            default: ;
        endcase
    end

    assign PC_addr = pc_q;
    assign IR_out  = ir_q;
    assign State   = state_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit. An instruction-level model of the
// program expands each instruction into its per-cycle control record and
// queues it; a negedge monitor pops one record per cycle and compares.
module tb_proc_control_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Instr_data;
    logic [6:0]  PC_addr;
    logic [15:0] IR_out;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  State;
    logic        Halted;

    proc_control_unit #(.PC_W(7), .D_AW(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Instr_data (Instr_data),
        .PC_addr    (PC_addr),
        .IR_out     (IR_out),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .State      (State),
        .Halted     (Halted)
    );

    always #5 Clk = ~Clk;

    logic [15:0] rom [0:127];
    assign Instr_data = rom[PC_addr];

    typedef struct packed {
        logic [3:0]  state;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  wa;
        logic        wen;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
    } rec_t;

    rec_t exp_q[$];
    int   limit;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic rec_t idle_rec(logic [3:0] st, int pc, logic [15:0] ir);
        rec_t r;
        r        = '0;
        r.state  = st;
        r.pc     = 7'(pc);
        r.ir     = ir;
        return r;
    endfunction

    task automatic push(rec_t r);
        if (exp_q.size() < limit) exp_q.push_back(r);
    endtask

    // Walk the program instruction by instruction and emit n cycle records
    task automatic build_trace(int n);
        int          pc;
        logic [15:0] ir;
        rec_t        r;
        exp_q.delete();
        limit = n;
        pc = 0;
        ir = 16'h0000;
        push(idle_rec(4'd0, pc, ir));
        while (exp_q.size() < n) begin
            push(idle_rec(4'd1, pc, ir));
            ir = rom[pc];
            pc = (pc + 1) % 128;
            push(idle_rec(4'd2, pc, ir));
            case (ir[15:12])
                4'h1: begin
                    r = idle_rec(4'd6, pc, ir);
                    r.ra = ir[11:8]; r.d_addr = ir[7:0]; r.d_wr = 1'b1;
                    push(r);
                end
                4'h2: begin
                    r = idle_rec(4'd4, pc, ir);
                    r.d_addr = ir[11:4]; r.rf_s = 1'b1; r.wa = ir[3:0];
                    push(r);
                    r.state = 4'd5; r.wen = 1'b1;
                    push(r);
                end
                4'h3, 4'h4: begin
                    r = idle_rec((ir[15:12] == 4'h3) ? 4'd7 : 4'd8, pc, ir);
                    r.ra = ir[11:8]; r.rb = ir[7:4]; r.wa = ir[3:0]; r.wen = 1'b1;
                    r.alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
                    push(r);
                end
                4'h5: begin
                    r = idle_rec(4'd9, pc, ir);
                    r.halted = 1'b1;
                    while (exp_q.size() < n) push(r);
                end
                default: push(idle_rec(4'd3, pc, ir));
            endcase
        end
    endtask

    always @(negedge Clk) begin
        rec_t act, e;
        if (mon_en && exp_q.size() > 0) begin
            act = '{state: State, pc: PC_addr, ir: IR_out, d_addr: D_addr, d_wr: D_wr,
                    rf_s: RF_s, wa: RF_W_addr, wen: RF_W_en, ra: RF_Ra_addr,
                    rb: RF_Rb_addr, alu: ALU_s0, halted: Halted};
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL trace t=%0t: got state=%0d pc=%0d rec=%h, expected state=%0d pc=%0d rec=%h",
                         $time, act.state, act.pc, act, e.state, e.pc, e);
            end
            checks++;
            if (D_wr && RF_W_en) begin
                errors++;
                $display("FAIL wr_excl t=%0t: D_wr=%b RF_W_en=%b, required not both 1",
                         $time, D_wr, RF_W_en);
            end
        end
    end

    task automatic run(int n);
        Reset = 1'b1;
        @(posedge Clk);
        build_trace(n);
        #1 Reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < n + 5 && exp_q.size() > 0; i++) @(posedge Clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic random_rom(bit allow_halt);
        logic [31:0] rnd;
        int          op;
        for (int i = 0; i < 128; i++) begin
            rnd = $urandom();
            op  = int'($urandom_range(0, 9));
            if (op == 5) op = (allow_halt && $urandom_range(0, 7) == 0) ? 5 : 3;
            else if (op > 5) op = int'($urandom_range(6, 15));
            rom[i] = {4'(op), rnd[11:0]};
        end
    endtask

    initial begin
        // All-NOOP program; also covers the PC wrap 127 -> 0
        clear_rom();
        run(10);
        run(400);

        // ADD, SUB, LOAD, then HALT at PC 3
        clear_rom();
        rom[0] = 16'h3125; rom[1] = 16'h4347; rom[2] = 16'h21A3; rom[3] = 16'h5000;
        run(40);
        check("halt_pc", 32'(PC_addr), 32'd4);
        check("halted", 32'(Halted), 32'd1);

        // STORE, undefined opcode, HALT
        clear_rom();
        rom[0] = 16'h1B42; rom[1] = 16'hF000; rom[2] = 16'h5000;
        run(20);

        // Reset asserted between edges while in LOAD_B
        clear_rom();
        rom[0] = 16'h21A3;
        Reset = 1'b1;
        @(posedge Clk);
        build_trace(100);
        #1 Reset = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(posedge Clk);
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        check("pre_rst_state", 32'(State), 32'd5);
        check("pre_rst_wen", 32'(RF_W_en), 32'd1);
        Reset = 1'b1;
        #1;
        check("async_state", 32'(State), 32'd0);
        check("async_pc", 32'(PC_addr), 32'd0);
        check("async_ir", 32'(IR_out), 32'd0);
        check("async_ctrl", {D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr,
                             RF_Rb_addr, ALU_s0, Halted}, 32'd0);

        // Random programs, with and without HALT
        for (int k = 0; k < 6; k++) begin
            random_rom(1'b1);
            run(300);
        end
        random_rom(1'b0);
        run(800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
